// File: rtl/calc_pkg.sv
// Shared constants for the calculator output stage: segment codes, FSM states
// and the BCD-digit-to-segment encoder.
package calc_pkg;

  // Segment codes are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SHOW = 2'd2
  } disp_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin8_to_bcd.sv
// Sequential double-dabble: latches din on start, runs eight add-3/shift
// iterations (one per clock) and then holds done high for one commit cycle.
module bin8_to_bcd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  output logic       done,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic        run_q;
  logic [3:0]  cnt_q;
  logic [7:0]  sr_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      sr_q  <= '0;
      bcd_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      sr_q  <= din;
      bcd_q <= '0;
    end else if (run_q) begin
      if (cnt_q == 4'd8) begin
        run_q <= 1'b0;
      end else begin
        {bcd_q, sr_q} <= {bcd_adj[10:0], sr_q, 1'b0};
        cnt_q         <= cnt_q + 4'd1;
      end
    end
  end

  assign done = run_q && (cnt_q == 4'd8);
  assign hund = bcd_q[11:8];
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/calc_result_display.sv
// Calculator output stage: captures result/err, converts to BCD and scans a
// 4-digit active-low 7-segment display with leading-zero blanking or "Err".
module calc_result_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] result,
  input  logic       err,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(REFRESH_DIV - 1);

  disp_state_e     state_q;
  logic            busy_q;
  logic            err_q;
  logic [3:0][6:0] disp_q;
  logic [CW-1:0]   scan_cnt_q;
  logic [1:0]      idx_q;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;

  logic            accept;
  logic            conv_done;
  logic [3:0]      hund, tens, ones;
  logic [3:0][6:0] disp_d;

  assign accept = load && (state_q != ST_CONV);

  bin8_to_bcd u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .din   (result),
    .done  (conv_done),
    .hund  (hund),
    .tens  (tens),
    .ones  (ones)
  );

  // Leading-zero blanking: tens is only suppressed when hundreds is too.
  always_comb begin
    disp_d[3] = SEG_BLANK;
    if (err_q) begin
      disp_d[2] = SEG_E;
      disp_d[1] = SEG_R;
      disp_d[0] = SEG_R;
    end else begin
      disp_d[2] = (hund == 4'd0) ? SEG_BLANK : seg_encode(hund);
      disp_d[1] = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_encode(tens);
      disp_d[0] = seg_encode(ones);
    end
  end

  // NOTE: the display registers are a handful of flops, so they take the
  // async reset to blank like all other state rather than being left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      disp_q  <= {4{SEG_BLANK}};
    end else begin
      case (state_q)
        ST_IDLE, ST_SHOW: begin
          if (accept) begin
            err_q   <= err;
            busy_q  <= 1'b1;
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            disp_q  <= disp_d;
            busy_q  <= 1'b0;
            state_q <= ST_SHOW;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1111;
      seg_q      <= SEG_BLANK;
    end else begin
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
        idx_q      <= idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= disp_q[idx_q];
    end
  end

  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display with REFRESH_DIV=4: reset scan,
// decimal/blanking/Err content, dropped loads and mid-conversion reset.
module tb_calc_result_display;

  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S_0  = 7'b1000000;
  localparam logic [6:0] S_1  = 7'b1111001;
  localparam logic [6:0] S_2  = 7'b0100100;
  localparam logic [6:0] S_4  = 7'b0011001;
  localparam logic [6:0] S_5  = 7'b0010010;
  localparam logic [6:0] S_7  = 7'b1111000;
  localparam logic [6:0] S_E  = 7'b0000110;
  localparam logic [6:0] S_R  = 7'b0101111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] result = '0;
  logic       err = 1'b0;
  logic       load = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;

  calc_result_display #(.REFRESH_DIV(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .result (result),
    .err    (err),
    .load   (load),
    .busy   (busy),
    .seg    (seg),
    .an     (an),
    .dp     (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse load for one edge with the given operands.
  task automatic do_load(input logic [7:0] r, input logic e);
    result = r;
    err    = e;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_busy_timeout"}, 32'(busy), 32'd0);
  endtask

  // Wait (bounded) until digit d is enabled, then compare its segments.
  task automatic check_digit(input string tag, input int d, input logic [6:0] exp);
    logic [3:0] want;
    int n = 0;
    want = ~(4'b0001 << d);
    while (an !== want && n < 24) begin
      tick();
      n++;
    end
    check({tag, "_an"}, 32'(an), 32'(want));
    check({tag, "_seg"}, 32'(seg), 32'(exp));
  endtask

  task automatic check_all(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                           input logic [6:0] d1, input logic [6:0] d0);
    check_digit({tag, "_d0"}, 0, d0);
    check_digit({tag, "_d1"}, 1, d1);
    check_digit({tag, "_d2"}, 2, d2);
    check_digit({tag, "_d3"}, 3, d3);
  endtask

  initial begin
    int nb;

    // Reset values while held
    repeat (3) tick();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'(S_BL));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dp", 32'(dp), 32'd1);

    // Release and observe the blank scan, one digit per 4 cycles
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("scan0_an", 32'(an), 32'hE);
    check("scan0_seg", 32'(seg), 32'(S_BL));
    repeat (4) tick();
    check("scan1_an", 32'(an), 32'hD);
    check("scan1_seg", 32'(seg), 32'(S_BL));
    repeat (4) tick();
    check("scan2_an", 32'(an), 32'hB);
    check("scan2_seg", 32'(seg), 32'(S_BL));
    repeat (4) tick();
    check("scan3_an", 32'(an), 32'h7);
    check("scan3_seg", 32'(seg), 32'(S_BL));
    repeat (4) tick();
    check("scan4_an", 32'(an), 32'hE);

    // result=4: busy for exactly 9 cycles, single lit digit
    do_load(8'd4, 1'b0);
    nb = 0;
    while (busy && nb < 30) begin
      nb++;
      tick();
    end
    check("busy_len", 32'(nb), 32'd9);
    tick();
    check_all("r4", S_BL, S_BL, S_BL, S_4);

    // result=205: inner zero is not blanked
    do_load(8'd205, 1'b0);
    wait_idle("r205");
    tick();
    check_all("r205", S_BL, S_2, S_0, S_5);

    // result=0: only the ones digit shows 0
    do_load(8'd0, 1'b0);
    wait_idle("r0");
    tick();
    check_all("r0", S_BL, S_BL, S_BL, S_0);

    // Error flag shows "Err" regardless of result
    do_load(8'hFF, 1'b1);
    err = 1'b0;
    wait_idle("err");
    tick();
    check_all("err", S_BL, S_E, S_R, S_R);

    // Load during CONV is dropped
    do_load(8'd100, 1'b0);
    tick();
    tick();
    check("drop_busy", 32'(busy), 32'd1);
    do_load(8'd7, 1'b0);
    wait_idle("drop");
    // First busy=0 cycle: load is accepted again
    do_load(8'd7, 1'b0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_idle("b2b");
    tick();
    check_all("b2b", S_BL, S_BL, S_BL, S_7);

    // Re-run the dropped case and inspect the 100 display
    do_load(8'd100, 1'b0);
    tick();
    tick();
    do_load(8'd7, 1'b0);
    wait_idle("r100");
    tick();
    check_all("r100", S_BL, S_1, S_0, S_0);

    // Reset in the middle of a conversion
    do_load(8'd200, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'(S_BL));
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all("post_rst", S_BL, S_BL, S_BL, S_BL);
    check("post_rst_busy", 32'(busy), 32'd0);

    do_load(8'd42, 1'b0);
    wait_idle("r42");
    tick();
    check_all("r42", S_BL, S_BL, S_4, S_2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
